muldiv_ctrl: RTL and testbench
==============================

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state changes on rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: start  in  1  execute-stage mult/div request, level, held while stall=1.
REQ-004 SHALL have ports: op  in  2  00=MULT, 01=MULTU, 10=DIV, 11=DIVU; sampled with start.
REQ-005 SHALL have ports: srca, srcb  in  32 each  operands (rs, rt); sampled with start.
REQ-006 SHALL have ports: flush  in  1  exception/eret cancel.
REQ-007 SHALL have ports: hi_we, lo_we  in  1 each; hilo_wdata  in  32  MTHI/MTLO write.
REQ-008 SHALL have ports: stall  out  1  freezes IF/ID/EX while an operation is in flight.
REQ-009 SHALL have ports: done  out  1  one-cycle completion pulse.
REQ-010 SHALL have ports: hi, lo  out  32 each  architectural HI/LO registers.

Function
REQ-011 SHALL implement states IDLE, MUL, DIV_RUN, DIV_FIX, DONE.
REQ-012 SHALL leave IDLE only on start=1 and flush=0: op[1]=0 -> MUL; op[1]=1 -> DIV_RUN; operands latched internally on that edge.
REQ-013 MUL SHALL last exactly 1 cycle, forming the 64-bit signed (MULT) or unsigned (MULTU) product, then go to DONE.
REQ-014 DIV_RUN SHALL perform a radix-2 restoring divide on operand magnitudes over exactly 32 cycles, using a 5-bit iteration counter that is 0 on entry and exits at 31.
REQ-015 DIV_FIX SHALL last 1 cycle and apply signs for DIV only: quotient negated if the operand signs differ; remainder takes the sign of the dividend.
REQ-016 DONE SHALL last 1 cycle with done=1; hi/lo SHALL be updated on the edge entering DONE (MUL: hi=product[63:32], lo=product[31:0]; DIV: hi=remainder, lo=quotient); next state IDLE.
REQ-017 SHALL yield latency from the start-accept edge to done=1: 2 cycles for mult, 34 cycles for div.
REQ-018 stall SHALL be combinational, = (state in {MUL, DIV_RUN, DIV_FIX}) OR (state==IDLE AND start AND !flush); stall SHALL be 0 in DONE.
REQ-019 start asserted in DONE SHALL be ignored (same instruction advancing); start outside IDLE SHALL be ignored.
REQ-020 flush=1 in any state SHALL force next state IDLE, suppress the hi/lo update and done, and take priority over start.
REQ-021 Divide by zero (srcb=0) SHALL give hi=srca, lo=32'hFFFFFFFF for both DIV and DIVU.
REQ-022 DIV 32'h80000000 / 32'hFFFFFFFF SHALL give lo=32'h80000000, hi=0.
REQ-023 hi_we/lo_we SHALL write hilo_wdata to hi/lo only in IDLE; in IDLE with start on the same edge, the write SHALL apply and the operation SHALL still start; in other states the write SHALL be ignored.

Reset
REQ-024 rst=1 SHALL set state=IDLE, counter=0, hi=0, lo=0, done=0, and the internal operand/partial registers to 0.
REQ-025 stall SHALL be 0 during reset regardless of start; reset mid-operation SHALL abandon it with no hi/lo update.
REQ-026 rst SHALL take priority over flush and start.

Configuration
REQ-027 Macro MULDIV_DIVZERO_FAST_EN: when defined, a divide with srcb=0 SHALL go IDLE -> DIV_FIX -> DONE, giving 2-cycle latency and the REQ-021 result.
REQ-028 When MULDIV_DIVZERO_FAST_EN is undefined, a divide by zero SHALL run the full 34 cycles with the identical REQ-021 result.

Verification
REQ-029 MULTU 0xFFFFFFFF*0xFFFFFFFF -> stall high 2 cycles, done at +2, hi=0xFFFFFFFE, lo=0x00000001.
REQ-030 MULT 0xFFFFFFFE*0x00000003 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA; DIV 0xFFFFFFF9/0x00000002 -> done at +34, lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-031 DIVU 100/0, macro off then on -> done at +34 then +2; hi=100, lo=0xFFFFFFFF in both.
REQ-032 DIVU 7/2 with flush at cycle +10 -> IDLE next cycle, done never asserted, hi/lo unchanged, stall=0; a new start is then accepted.
REQ-033 Start held through DONE -> exactly one done pulse, no restart; hi_we with hilo_wdata=0x1234 during DIV_RUN -> hi unchanged; the same write in IDLE -> hi=0x1234.
REQ-034 rst asserted mid-DIV_RUN -> next cycle state IDLE, hi=lo=0, done=0, stall=0.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multi-cycle MIPS-style mult/div unit with architectural HI/LO.
// MULT/MULTU take one execute cycle; DIV/DIVU run a 32-step restoring divide
// on operand magnitudes followed by one sign-fix cycle.
// Optional build macro MULDIV_DIVZERO_FAST_EN: divide by zero skips the
// 32-step loop and goes straight to the sign-fix cycle.
module muldiv_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] srca,
    input  logic [31:0] srcb,
    input  logic        flush,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] hilo_wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [2:0] {IDLE, MUL, DIV_RUN, DIV_FIX, DONE} state_t;

    state_t      state, state_n;
    logic [4:0]  cnt;
    logic        op_uns;
    logic [31:0] opa, opb;
    logic [31:0] rem, quo, dvs;

    logic        accept;
    logic [63:0] prod;
    logic [32:0] rem_sh;
    logic [31:0] sub;
    logic        ge;
    logic [31:0] fix_hi, fix_lo;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state logic; flush overrides every transition
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (start && !flush) begin
                    if (!op[1]) state_n = MUL;
`ifdef MULDIV_DIVZERO_FAST_EN
                    else if (srcb == '0) state_n = DIV_FIX;
`endif
                    else state_n = DIV_RUN;
                end
            end
            MUL:     state_n = DONE;
            DIV_RUN: if (cnt == 5'd31) state_n = DIV_FIX;
            DIV_FIX: state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (flush) state_n = IDLE;
    end

    // Handshake outputs; stall is combinational so the pipeline freezes in the accept cycle
    always_comb begin
        accept = (state == IDLE) && start && !flush;
        stall  = !rst && (accept || state == MUL || state == DIV_RUN || state == DIV_FIX);
        done   = !rst && !flush && (state == DONE);
    end

    // Arithmetic: one 64-bit product, one restoring-divide step, final sign fix
    always_comb begin
        prod   = {{32{!op_uns & opa[31]}}, opa} * {{32{!op_uns & opb[31]}}, opb};
        rem_sh = {rem, quo[31]};
        ge     = rem_sh >= {1'b0, dvs};
        // low 32 bits of the difference are exact whenever ge holds, since rem < dvs
        sub    = rem_sh[31:0] - dvs;
        if (opb == '0) begin
            fix_hi = opa;
            fix_lo = '1;
        end else begin
            fix_lo = (!op_uns && (opa[31] ^ opb[31])) ? -quo : quo;
            fix_hi = (!op_uns && opa[31]) ? -rem : rem;
        end
    end

    // Operand capture, divide iteration, and HI/LO updates
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            op_uns <= 1'b0;
            opa    <= '0;
            opb    <= '0;
            rem    <= '0;
            quo    <= '0;
            dvs    <= '0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            cnt <= (state == DIV_RUN && !flush) ? cnt + 5'd1 : '0;
            if (accept) begin
                op_uns <= op[0];
                opa    <= srca;
                opb    <= srcb;
                rem    <= '0;
                quo    <= (!op[0] && srca[31]) ? -srca : srca;
                dvs    <= (!op[0] && srcb[31]) ? -srcb : srcb;
            end else if (state == DIV_RUN) begin
                rem <= ge ? sub : rem_sh[31:0];
                quo <= {quo[30:0], ge};
            end
            if (state == IDLE) begin
                if (hi_we) hi <= hilo_wdata;
                if (lo_we) lo <= hilo_wdata;
            end else if (state == MUL && !flush) begin
                {hi, lo} <= prod;
            end else if (state == DIV_FIX && !flush) begin
                hi <= fix_hi;
                lo <= fix_lo;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Testbench for muldiv_ctrl: directed and random mult/div operations checked
// against an arithmetic reference, plus flush, reset and HI/LO write cases.
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, flush, hi_we, lo_we;
    logic [1:0]  op;
    logic [31:0] srca, srcb, hilo_wdata;
    logic        stall, done;
    logic [31:0] hi, lo;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] model_hilo = '0;

    muldiv_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .srca(srca), .srcb(srcb),
        .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .hilo_wdata(hilo_wdata),
        .stall(stall), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Architectural result {hi, lo} from plain integer arithmetic
    function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (o)
            2'b00: return 64'(sa * sb);
            2'b01: return ua * ub;
            default: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                if (o == 2'b10) begin
                    q = sa / sb;
                    r = sa % sb;
                    return {r[31:0], q[31:0]};
                end
                return {a % b, a / b};
            end
        endcase
    endfunction

    function automatic int ref_latency(input logic [1:0] o, input logic [31:0] b);
        if (!o[1]) return 2;
`ifdef MULDIV_DIVZERO_FAST_EN
        if (b == 32'd0) return 2;
`endif
        return (b == 32'd0) ? 34 : 34;
    endfunction

    // Issue one instruction, holding start through DONE as a stalled pipeline would.
    // hiwe_cyc: pulse an MTHI of 0x1234 in that busy cycle (0 = none).
    // lowe_start: MTLO of 0xABCD on the accept edge.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int hiwe_cyc, input bit lowe_start);
        logic [63:0] exp;
        int lat;
        exp = ref_result(o, a, b);
        lat = ref_latency(o, b);
        @(negedge clk);
        start = 1'b1; op = o; srca = a; srcb = b;
        if (lowe_start) begin
            lo_we = 1'b1; hilo_wdata = 32'h0000ABCD;
        end
        #1 check_eq("stall_accept", {63'd0, stall}, 64'd1);
        for (int k = 1; k <= lat; k++) begin
            @(posedge clk);
            #1;
            hi_we = 1'b0;
            lo_we = 1'b0;
            if (k == 1 && lowe_start) check_eq("mtlo_with_start", {32'd0, lo}, 64'h0000ABCD);
            if (k < lat) begin
                check_eq($sformatf("busy op%0d k%0d", o, k), {62'd0, stall, done}, 64'd2);
            end else begin
                check_eq($sformatf("done op%0d %h %h", o, a, b), {62'd0, stall, done}, 64'd1);
                check_eq($sformatf("hilo op%0d %h %h", o, a, b), {hi, lo}, exp);
            end
            if (k == hiwe_cyc) begin
                hi_we = 1'b1; hilo_wdata = 32'h00001234;
            end
        end
        model_hilo = exp;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1 check_eq("no_restart", {62'd0, stall, done}, 64'd0);
        check_eq("hilo_hold", {hi, lo}, model_hilo);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h80000000;
            2: return 32'hFFFFFFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int dn;
        rst = 1'b1; start = 1'b1; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        op = 2'b00; srca = '0; srcb = '0; hilo_wdata = '0;
        #1 check_eq("stall_in_reset", {63'd0, stall}, 64'd0);
        repeat (2) @(posedge clk);
        #1 check_eq("reset_hilo", {hi, lo}, 64'd0);
        check_eq("reset_flags", {62'd0, stall, done}, 64'd0);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;

        // Directed cases
        do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0);
        do_op(2'b00, 32'hFFFFFFFE, 32'h00000003, 0, 1'b0);
        do_op(2'b10, 32'hFFFFFFF9, 32'h00000002, 0, 1'b0);
        do_op(2'b11, 32'd100, 32'd0, 0, 1'b0);
        do_op(2'b10, 32'hFFFFFF9C, 32'd0, 0, 1'b0);
        do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 0, 1'b0);
        do_op(2'b11, 32'd7, 32'd2, 5, 1'b0);
        do_op(2'b00, 32'd9, 32'd9, 1, 1'b0);
        do_op(2'b11, 32'hDEADBEEF, 32'd1000, 0, 1'b1);

        // MTHI in IDLE
        @(negedge clk);
        hi_we = 1'b1; hilo_wdata = 32'h00001234;
        @(posedge clk);
        #1 hi_we = 1'b0;
        model_hilo[63:32] = 32'h00001234;
        check_eq("mthi_idle", {hi, lo}, model_hilo);

        // Flush mid-divide
        @(negedge clk);
        start = 1'b1; op = 2'b11; srca = 32'd7; srcb = 32'd2;
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush = 1'b1; start = 1'b0;
        @(posedge clk);
        #1 check_eq("flush_idle", {62'd0, stall, done}, 64'd0);
        check_eq("flush_hilo", {hi, lo}, model_hilo);
        flush = 1'b0;
        dn = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1 if (done) dn++;
        end
        check_eq("flush_no_done", dn, 0);
        check_eq("flush_hilo_late", {hi, lo}, model_hilo);
        do_op(2'b01, 32'd6, 32'd7, 0, 1'b0);

        // Reset mid-divide
        @(negedge clk);
        start = 1'b1; op = 2'b10; srca = 32'd1000; srcb = 32'd3;
        repeat (12) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1 check_eq("stall_rst_mid", {63'd0, stall}, 64'd0);
        @(posedge clk);
        #1 check_eq("rst_mid_flags", {62'd0, stall, done}, 64'd0);
        check_eq("rst_mid_hilo", {hi, lo}, 64'd0);
        model_hilo = '0;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        do_op(2'b10, 32'd1000, 32'd3, 0, 1'b0);

        // Random operations
        for (int i = 0; i < 40; i++) begin
            do_op(2'($urandom_range(0, 3)), pick(), pick(), 0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
